// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a run of consecutive words out of a synchronous
// block ROM onto a valid/ready interface with a last flag. The ROM's one-cycle
// read latency is absorbed by a single in-flight stage feeding a 3-entry FIFO.
// The issue decision depends only on registered state, so there is no
// combinational path from m_ready back to the ROM address.
module rom_stream_reader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [ADDRESS_WIDTH:0]   count,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]    m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);

    localparam int FIFO_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [ADDRESS_WIDTH:0] remaining;

    // Read in flight: the ROM sampled rom_addr at the last edge and its word
    // is on rom_data during this cycle.
    logic                   rd_vld_p1;
    logic                   rd_last_p1;

    logic [DATA_WIDTH-1:0]  fifo_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  fifo_last;
    logic [1:0]             rd_ptr;
    logic [1:0]             wr_ptr;
    logic [1:0]             occupancy;

    logic                   issue;
    logic                   push;
    logic                   pop;

    // Wrap a FIFO pointer over the three entries.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue only while the FIFO plus the in-flight word leave room for one more.
    always_comb begin
        issue = (state == RUN) && (remaining != '0) &&
                (({1'b0, occupancy} + {2'b00, rd_vld_p1}) < 3'd3);
        push  = rd_vld_p1;
        pop   = m_valid && m_ready;
    end

    // FIFO head drives the stream outputs directly.
    always_comb begin
        m_valid = (occupancy != 2'd0);
        m_data  = fifo_data[rd_ptr];
        m_last  = fifo_last[rd_ptr];
    end

    // Run control: address generation, word countdown, busy/done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rom_addr   <= '0;
            remaining  <= '0;
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= 1'b0;
            rd_vld_p1 <= issue;
            if (issue) begin
                rom_addr   <= rom_addr + 1'b1;
                remaining  <= remaining - 1'b1;
                rd_last_p1 <= (remaining == {{ADDRESS_WIDTH{1'b0}}, 1'b1});
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            rom_addr  <= start_addr;
                            remaining <= count;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue && (remaining == {{ADDRESS_WIDTH{1'b0}}, 1'b1})) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last-flagged handshake implies FIFO and in-flight
                    // stage are both empty afterwards.
                    if (pop && m_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture FIFO: push the in-flight ROM word, pop on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= 2'd0;
            wr_ptr    <= 2'd0;
            occupancy <= 2'd0;
            fifo_last <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_data;
                fifo_last[wr_ptr] <= rd_last_p1;
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Testbench for rom_stream_reader: a behavioural synchronous ROM, a
// scoreboard queue of expected beats filled when a run is started, and a
// negedge monitor that checks beats, stall stability and done timing.
module tb_rom_stream_reader;

    localparam int DW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   count;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] rom_mem [2**AW];
    logic [DW:0]   exp_q [$];
    int            n_vec = 0;
    int            n_err = 0;
    int            beats = 0;
    bit            rdy_rand = 1'b0;

    always #5 clk = ~clk;

    rom_stream_reader #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous ROM with one cycle of read latency.
    always_ff @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer ready: held high, or random when back-pressure is exercised.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: beat order/content, stall stability, done timing.
    bit          done_due   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [DW:0] prev_beat;
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_due   = 1'b0;
                prev_stall = 1'b0;
            end else begin
                check("done", 32'(done), 32'(done_due));
                if (prev_stall) begin
                    check("stall_valid", 32'(m_valid), 32'(1));
                    check("stall_beat", 32'({m_last, m_data}), 32'(prev_beat));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(1), 32'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 32'(m_data), 32'(e[DW-1:0]));
                        check("beat_last", 32'(m_last), 32'(e[DW]));
                    end
                    beats++;
                end
                done_due   = (m_valid && m_ready && m_last) || (start && (count == '0));
                prev_stall = m_valid && !m_ready;
                prev_beat  = {m_last, m_data};
            end
        end
    end

    // Drive one start pulse and queue the beats it should produce; returns
    // just after the sampling edge E0.
    task automatic start_run(input logic [AW-1:0] sa, input int cnt);
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = sa;
        count      = (AW+1)'(cnt);
        for (int i = 0; i < cnt; i++) begin
            a = AW'(int'(sa) + i);
            exp_q.push_back({(i == cnt - 1), rom_mem[a]});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Start a run and check address sequence and first-valid latency.
    task automatic run_latency(input logic [AW-1:0] sa, input int cnt);
        logic [AW-1:0] a;
        start_run(sa, cnt);
        @(negedge clk);
        check("lat_addr_e0", 32'(rom_addr), 32'(sa));
        check("lat_busy_e0", 32'(busy), 32'(1));
        check("lat_valid_e0", 32'(m_valid), 32'(0));
        @(negedge clk);
        a = sa + 3'd1;
        check("lat_addr_e1", 32'(rom_addr), 32'(a));
        check("lat_valid_e1", 32'(m_valid), 32'(0));
        @(negedge clk);
        a = sa + 3'd2;
        check("lat_addr_e2", 32'(rom_addr), 32'(a));
        check("lat_valid_e2", 32'(m_valid), 32'(1));
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        if (k == 400) check("timeout_idle", 32'(0), 32'(1));
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, 32'(m_valid), 32'(0));
        check({tag, "_last"}, 32'(m_last), 32'(0));
        check({tag, "_data"}, 32'(m_data), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
        check({tag, "_addr"}, 32'(rom_addr), 32'(0));
    endtask

    initial begin
        int base;
        int k;
        for (int i = 0; i < 2**AW; i++) rom_mem[i] = 8'h10 + 8'(i) * 8'h23;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Basic run with ready held high.
        run_latency(3'd2, 4);
        wait_idle();

        // Address wrap 6,7,0,1.
        start_run(3'd6, 4);
        wait_idle();

        // Full-depth run under random back-pressure, then a shorter one.
        rdy_rand = 1'b1;
        start_run(3'd0, 8);
        wait_idle();
        start_run(3'd5, 7);
        wait_idle();
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;

        // Zero-length run: done only, no beats, never busy.
        start_run(3'd3, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("cnt0_busy", 32'(busy), 32'(0));
            check("cnt0_valid", 32'(m_valid), 32'(0));
        end

        // Start while busy is ignored.
        start_run(3'd1, 5);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 3'd6;
        count      = 4'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset mid-run after two beats, then a fresh run.
        base = beats;
        start_run(3'd4, 6);
        for (k = 0; k < 50 && beats < base + 2; k++) @(negedge clk);
        if (k == 50) check("timeout_beats", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idle_valid", 32'(m_valid), 32'(0));
        run_latency(3'd5, 3);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
